uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a configurable word length, optional parity and a show-ahead receive FIFO. It replaces the fixed 8N1 `UART` receiver, which had no handshake, in the ALU input path. It deserialises asynchronous `uart_rx` frames and presents them on a valid/ready interface. Malformed frames and overflowed words are discarded and each is reported with a one-cycle error pulse.

## Interface
- `CLOCK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate; `CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE` (integer divide; 434 at defaults).
- `DATA_BITS`, 8: data bits per frame, legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2, minimum 2.

- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial line. Idle high, LSB first, one start bit, one stop bit.
- `rx_data` out DATA_BITS: FIFO head word; 0 when the FIFO is empty.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accept; a pop occurs when `rx_valid && rx_ready`.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on a parity mismatch.
- `overrun` out 1: one-cycle pulse when a good word is dropped because the FIFO is full.
- `fifo_count` out $clog2(FIFO_DEPTH+1): number of occupied entries.

## Operation
- Input synchronisation: `uart_rx` passes through a 2-FF synchroniser; both flops reset to 1. All FSM logic uses the synchronised value `rxs`.
- A falling edge is `rxs`=0 with the previous `rxs`=1. A line held low does not retrigger the receiver.
- FSM states: IDLE, START, DATA, PAR, STOP. A bit counter `cnt` and a bit index `idx` drive the sampling.
- IDLE: on a falling edge go to START with `cnt`=0.
- START: when `cnt`=CLKS_PER_BIT/2−1, sample `rxs`.
  - If 1: false start; return to IDLE with no pulse.
  - If 0: go to DATA with `cnt`=0 and `idx`=0.
- DATA: when `cnt`=CLKS_PER_BIT−1, shift `rxs` into `shreg[idx]`.
  - After bit DATA_BITS−1, go to PAR if PARITY≠0, otherwise go to STOP.
- PAR: sample after CLKS_PER_BIT cycles, then go to STOP.
  - Odd mode: the XOR of the data bits and the parity bit must equal 1.
  - Even mode: the same XOR must equal 0.
- STOP: sample after CLKS_PER_BIT cycles, i.e. mid stop bit, then return to IDLE on the same edge. This permits back-to-back frames.
  - Stop sampled 0: pulse `frame_err` and discard the word. `frame_err` takes priority; `parity_err` is not also pulsed.
  - Else, parity bad: pulse `parity_err` and discard the word.
  - Else: push the word to the FIFO.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a separate count.
  - Push with the FIFO full and no pop in the same cycle: drop the word, pulse `overrun`, keep the contents unchanged.
  - Push with the FIFO full and a pop in the same cycle: the push is accepted, there is no `overrun`, and the count is unchanged.
  - Push and pop in the same cycle on a non-empty FIFO: the count is unchanged.
  - Pop when empty: no effect.
- Reset asserted at any time, including mid-frame: the FSM goes to IDLE, the FIFO empties, and the partial frame is lost.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `fifo_count`=0. Synchroniser flops reset to 1; FSM resets to IDLE.
- Let t0 be the cycle in which the falling edge is seen on `rxs`, which is 2 cycles after the `uart_rx` edge.
- The start bit is sampled at t0+CLKS_PER_BIT/2. Bit k is sampled one CLKS_PER_BIT later per bit.
- With P = 1 if PARITY≠0, else 0, the stop bit is sampled at t0 + CLKS_PER_BIT/2 + (DATA_BITS+P+1)·CLKS_PER_BIT.
  - The push, or the error pulse, takes effect on that edge.
  - `rx_valid` and `rx_data` update in the following cycle.
- Show-ahead: `rx_data` is valid whenever `rx_valid`=1. After a pop, the next word, or 0, appears in the following cycle.
- Error pulses are exactly 1 cycle wide.

## Test plan
- Defaults, `rx_ready`=1, frames 0x5A, 0xA3, 0xB3 at 8680 ns/bit: `rx_valid` pulses once per frame with matching `rx_data`; no error pulses.
- `rx_ready`=0, 5 good frames with FIFO_DEPTH=4: `fifo_count` reaches 4 and `overrun` pulses once on frame 5. Then raise `rx_ready`: words 1–4 are popped in order, and `rx_valid` falls after the 4th.
- PARITY=2, DATA_BITS=7, frame 0x55 with the parity bit forced to 1: `parity_err` pulses once and `fifo_count` stays 0. The same frame with the correct parity bit 0 is received as 0x55.
- Frame 0x3C with the stop bit driven 0: `frame_err` pulses and nothing is pushed. After the line returns high, frame 0x3C is received correctly.
- 2000 ns low glitch on an idle line: false start is rejected; no push, no error pulse, and the FSM returns to IDLE.
- Assert `rst_n` low during bit 4 of a frame with 2 words queued: all outputs return to reset values immediately. Releasing reset with the line high and sending 0xC1 yields 0xC1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable word length, optional parity) feeding a show-ahead
// receive FIFO with valid/ready output and one-cycle error/overrun pulses.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               uart_rx,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic                 rx_meta, rxs, rxs_prev;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;

  logic                 bit_done_c, push_c, pop_c, full_c, wr_en_c;
  logic [PTR_W-1:0]     rd_next_c;
  logic [FCNT_W-1:0]    count_next_c;
  logic [DATA_BITS-1:0] head_next_c;

  // Two-flop synchroniser plus one history flop for edge detection; idle level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= uart_rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign bit_done_c = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Frame receiver: samples mid-bit, counting from the detected falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs && rxs_prev) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_W'(HALF_BIT - 1)) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              idx     <= '0;
              par_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done_c) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == IDX_W'(DATA_BITS - 1)) begin
              state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PAR: begin
          if (bit_done_c) begin
            cnt     <= '0;
            state   <= STOP;
            // Odd mode expects total XOR of 1, even mode expects 0.
            par_bad <= ((^shreg) ^ rxs) != (PARITY == 1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done_c) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rxs) begin
              frame_err <= 1'b1;
            end else if (par_bad) begin
              parity_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO control; a full FIFO still accepts a push when a pop frees a slot that cycle.
  always_comb begin
    push_c       = (state == STOP) && bit_done_c && rxs && !par_bad;
    pop_c        = rx_valid && rx_ready;
    full_c       = (fifo_count == FCNT_W'(FIFO_DEPTH));
    wr_en_c      = push_c && (!full_c || pop_c);
    rd_next_c    = rd_ptr + PTR_W'(pop_c);
    count_next_c = fifo_count + FCNT_W'(wr_en_c) - FCNT_W'(pop_c);
    head_next_c  = (wr_en_c && (wr_ptr == rd_next_c)) ? shreg : mem[rd_next_c];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // Registered show-ahead head: rx_data tracks the next-cycle head word, 0 when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun    <= push_c && full_c && !pop_c;
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr     <= rd_next_c;
      fifo_count <= count_next_c;
      rx_valid   <= (count_next_c != '0);
      rx_data    <= (count_next_c != '0) ? head_next_c : '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance at 115200 baud and a 7E1 instance
// at a faster rate; received words are scored against a queue of expected words.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BIT8 = 8680;   // 434 clocks of 20 ns
  localparam int BIT7 = 1000;   // 50 clocks of 20 ns

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1;
  logic       rx_ready0, rx_ready1;
  logic [7:0] rx_data0;
  logic [6:0] rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       frame_err0, frame_err1, parity_err0, parity_err1, overrun0, overrun1;
  logic [2:0] fifo_count0, fifo_count1;

  int checks = 0;
  int failures = 0;
  int fe0 = 0, pe0 = 0, ov0 = 0, pop0 = 0;
  int fe1 = 0, pe1 = 0, ov1 = 0, pop1 = 0;
  int pop_before;
  logic [7:0] q0 [$];
  logic [6:0] q1 [$];

  always #10 clk = ~clk;

  uart_rx_fifo #(.CLOCK_FREQ(50000000), .BAUD_RATE(115200)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .frame_err(frame_err0), .parity_err(parity_err0), .overrun(overrun0),
    .fifo_count(fifo_count0)
  );

  uart_rx_fifo #(.CLOCK_FREQ(50000000), .BAUD_RATE(1000000), .DATA_BITS(7), .PARITY(2)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .frame_err(frame_err1), .parity_err(parity_err1), .overrun(overrun1),
    .fifo_count(fifo_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    fe0 += int'(frame_err0);  pe0 += int'(parity_err0);  ov0 += int'(overrun0);
    fe1 += int'(frame_err1);  pe1 += int'(parity_err1);  ov1 += int'(overrun1);
    if (rx_valid0 && rx_ready0) begin
      pop0++;
      check("dut8_pop_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) check("dut8_rx_data", 32'(rx_data0), 32'(q0.pop_front()));
    end
    if (rx_valid1 && rx_ready1) begin
      pop1++;
      check("dut7_pop_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) check("dut7_rx_data", 32'(rx_data1), 32'(q1.pop_front()));
    end
  end

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic idle(input int which, input int ns);
    drive(which, 1'b1);
    #(ns);
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit, input logic stop_bit,
                            input int bit_ns);
    @(negedge clk);
    drive(which, 1'b0);
    #(bit_ns);
    for (int i = 0; i < nbits; i++) begin
      drive(which, data[i]);
      #(bit_ns);
    end
    if (has_par) begin
      drive(which, par_bit);
      #(bit_ns);
    end
    drive(which, stop_bit);
    #(bit_ns);
    drive(which, 1'b1);
  endtask

  task automatic set_ready0(input logic v);
    @(posedge clk);
    #1;
    rx_ready0 = v;
  endtask

  initial begin
    logic [7:0] w8 [3];
    logic [7:0] ov [5];
    logic [7:0] partial;
    w8 = '{8'h5A, 8'hA3, 8'hB3};
    ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    partial = 8'hE7;
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rx_ready0 = 1'b1; rx_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(rx_data0), 32'h0);
    check("rst_rx_valid", 32'(rx_valid0), 32'h0);
    check("rst_errs", 32'({frame_err0, parity_err0, overrun0}), 32'h0);
    check("rst_fifo_count", 32'(fifo_count0), 32'h0);
    rst_n = 1'b1;
    idle(0, 200);

    // Three back-to-back-ish good frames with the consumer always ready.
    for (int i = 0; i < 3; i++) begin
      q0.push_back(w8[i]);
      send_frame(0, 9'(w8[i]), 8, 1'b0, 1'b0, 1'b1, BIT8);
      idle(0, BIT8);
    end
    check("t1_pops", 32'(pop0), 32'd3);
    check("t1_queue_drained", 32'(q0.size()), 32'd0);
    check("t1_no_errs", 32'(fe0 + pe0 + ov0), 32'd0);
    check("t1_valid_low", 32'(rx_valid0), 32'd0);

    // Fill the FIFO with the consumer stalled; the fifth word overruns.
    set_ready0(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q0.push_back(ov[i]);
      send_frame(0, 9'(ov[i]), 8, 1'b0, 1'b0, 1'b1, BIT8);
      idle(0, BIT8);
    end
    check("t2_count_full", 32'(fifo_count0), 32'd4);
    check("t2_overrun_once", 32'(ov0), 32'd1);
    check("t2_head", 32'(rx_data0), 32'h11);
    check("t2_valid", 32'(rx_valid0), 32'd1);
    set_ready0(1'b1);
    repeat (8) @(negedge clk);
    check("t2_pops", 32'(pop0), 32'd7);
    check("t2_drained", 32'(q0.size()), 32'd0);
    check("t2_valid_low", 32'(rx_valid0), 32'd0);
    check("t2_data_zero", 32'(rx_data0), 32'h0);
    check("t2_count_zero", 32'(fifo_count0), 32'd0);

    // 7E1: 0x55 has four ones, so even parity bit is 0; sending 1 must be rejected.
    send_frame(1, 9'h55, 7, 1'b1, 1'b1, 1'b1, BIT7);
    idle(1, 3 * BIT7);
    check("t3_parity_err", 32'(pe1), 32'd1);
    check("t3_no_pop", 32'(pop1), 32'd0);
    check("t3_count", 32'(fifo_count1), 32'd0);
    q1.push_back(7'h55);
    send_frame(1, 9'h55, 7, 1'b1, 1'b0, 1'b1, BIT7);
    idle(1, 3 * BIT7);
    check("t3_good_pop", 32'(pop1), 32'd1);
    check("t3_parity_err_still1", 32'(pe1), 32'd1);
    check("t3_no_frame_err", 32'(fe1 + ov1), 32'd0);

    // Stop bit low: framing error, word discarded, then a clean retry.
    pop_before = pop0;
    send_frame(0, 9'h3C, 8, 1'b0, 1'b0, 1'b0, BIT8);
    idle(0, 2 * BIT8);
    check("t4_frame_err", 32'(fe0), 32'd1);
    check("t4_no_parity_err", 32'(pe0), 32'd0);
    check("t4_no_pop", 32'(pop0 - pop_before), 32'd0);
    q0.push_back(8'h3C);
    send_frame(0, 9'h3C, 8, 1'b0, 1'b0, 1'b1, BIT8);
    idle(0, BIT8);
    check("t4_retry_pop", 32'(pop0 - pop_before), 32'd1);

    // Short low glitch is shorter than half a bit: false start.
    pop_before = pop0;
    @(negedge clk);
    rx0 = 1'b0;
    #2000;
    idle(0, 2 * BIT8);
    check("t5_no_pop", 32'(pop0 - pop_before), 32'd0);
    check("t5_no_err", 32'(fe0 + pe0 + ov0), 32'd2);
    check("t5_count", 32'(fifo_count0), 32'd0);

    // Reset mid-frame with two words queued.
    set_ready0(1'b0);
    send_frame(0, 9'h0F, 8, 1'b0, 1'b0, 1'b1, BIT8);
    idle(0, BIT8);
    send_frame(0, 9'hF0, 8, 1'b0, 1'b0, 1'b1, BIT8);
    idle(0, BIT8);
    check("t6_queued", 32'(fifo_count0), 32'd2);
    @(negedge clk);
    rx0 = 1'b0;
    #(BIT8);
    for (int i = 0; i < 4; i++) begin
      rx0 = partial[i];
      #(BIT8);
    end
    rx0 = partial[4];
    #(BIT8 / 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(fifo_count0), 32'd0);
    check("t6_rst_valid", 32'(rx_valid0), 32'd0);
    check("t6_rst_data", 32'(rx_data0), 32'h0);
    check("t6_rst_errs", 32'({frame_err0, parity_err0, overrun0}), 32'h0);
    rx0 = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    set_ready0(1'b1);
    pop_before = pop0;
    q0.push_back(8'hC1);
    send_frame(0, 9'hC1, 8, 1'b0, 1'b0, 1'b1, BIT8);
    idle(0, BIT8);
    check("t6_c1_pop", 32'(pop0 - pop_before), 32'd1);
    check("end_q0_empty", 32'(q0.size()), 32'd0);
    check("end_q1_empty", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
